// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: framed, LSB-first serial-in/parallel-out receiver.
// Samples sdin only on clk edges with tick=1 and hands each good word to the
// consumer through a data_valid/ack handshake. It flags framing errors and
// overruns.
// Optional feature macro: SIPO_PARITY_EN adds one even-parity bit between the
// data bits and the stop bit, and drives parity_err.
module sipo_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sdin,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef SIPO_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_STOP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_data;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;

`ifdef SIPO_PARITY_EN
    logic             r_par_bit;
    logic             r_parity_err;
    logic             w_par_bad;

    // Even parity: data bits XOR parity bit must be 0 for a good frame.
    assign w_par_bad  = (^r_sr) ^ r_par_bit;
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

    // State register; a reset mid-frame drops straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every transition is gated by the bit-rate tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (tick && !sdin) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef SIPO_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    w_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: shifting, word hand-off, handshake and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_sr         <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses.
            r_frame_err <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // ack acts on any edge; an acceptance below on the same edge wins.
            if (ack) begin
                r_data_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (tick && !sdin) begin
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        r_sr      <= {sdin, r_sr[WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef SIPO_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        r_par_bit <= sdin;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (!sdin) begin
                            r_frame_err <= 1'b1;
                        end
`ifdef SIPO_PARITY_EN
                        else if (w_par_bad) begin
                            r_parity_err <= 1'b1;
                        end
`endif
                        else begin
                            r_data       <= r_sr;
                            r_data_valid <= 1'b1;
                            // Old word not yet taken and not taken now: lost.
                            if (r_data_valid && !ack) begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Testbench for sipo_frame_receiver (WIDTH=8). Build with +define+SIPO_PARITY_EN
// to exercise the parity variant; frames then carry a parity bit automatically.
module tb_sipo_frame_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         sdin;
    logic         ack;
    logic [W-1:0] data;
    logic         data_valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    sipo_frame_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sdin       (sdin),
        .ack        (ack),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick-qualified bit, followed by a tick=0 gap cycle.
    task automatic send_bit(input logic b, input logic a);
        @(negedge clk);
        sdin = b;
        tick = 1'b1;
        ack  = a;
        @(negedge clk);
        tick = 1'b0;
        ack  = 1'b0;
        sdin = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop_b,
                              input logic par_flip, input logic ack_stop);
        logic good;
        good = stop_b;
        send_bit(1'b0, 1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < W; i++) send_bit(w[i], 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit((^w) ^ par_flip, 1'b0);
        good = stop_b && !par_flip;
`endif
        if (good) exp_q.push_back(w);
        send_bit(stop_b, ack_stop);
    endtask

    // Pop the word expected from the last accepted frame and compare.
    task automatic drain(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=word", tag);
        end else begin
            while (exp_q.size() > 0) e = exp_q.pop_front();
            chk(tag, {24'd0, data}, {24'd0, e});
            chk({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        sdin = 1'b1;
        ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle line.
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_dv", {31'd0, data_valid}, 32'd0);

        // Good frame, then ack.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drain("good_a5");
        chk("good_busy", {31'd0, busy}, 32'd0);
        chk("good_ferr", {31'd0, frame_err}, 32'd0);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("ack_dv", {31'd0, data_valid}, 32'd0);
        chk("ack_data", {24'd0, data}, 32'h0A5);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("ack_idle_dv", {31'd0, data_valid}, 32'd0);

        // Framing error.
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("ferr_pulse", {31'd0, frame_err}, 32'd1);
        chk("ferr_dv", {31'd0, data_valid}, 32'd0);
        chk("ferr_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        chk("ferr_one_clk", {31'd0, frame_err}, 32'd0);
        chk("ferr_qempty", exp_q.size(), 32'd0);

        // Overrun.
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        drain("ovr_3c");
        chk("ovr_before", {31'd0, overrun}, 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        drain("ovr_c3");
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        repeat (3) @(negedge clk);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Acceptance and ack on the same edge.
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        drain("sim_3c");
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        drain("sim_55");
        chk("sim_ovr", {31'd0, overrun}, 32'd0);

        // Reset mid-frame.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_data", {24'd0, data}, 32'd0);
        chk("mid_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        drain("mid_81");
        chk("perr_tied", {31'd0, parity_err}, 32'd0);

`ifdef SIPO_PARITY_EN
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drain("par_good");
        chk("par_good_perr", {31'd0, parity_err}, 32'd0);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("par_bad_pulse", {31'd0, parity_err}, 32'd1);
        chk("par_bad_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        chk("par_bad_one_clk", {31'd0, parity_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
